regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of the register file and shares it between two
//  write-back requesters: req0 (ALU/EX result) and req1 (MEM/multi-cycle result).
//  Round-robin arbitration, registered output (we/waddr/wdata) into the regfile.
//  Keeps a pending-write scoreboard so decode can stall on RAW hazards.
// PARAMETERS
//  REG_NUM     32  number of architectural registers
//  REG_ADDR_W   5  register address width, log2(REG_NUM)
//  DATA_W      32  register data width
// PORTS
//  clk         in   1           clock, all state on posedge
//  rst         in   1           asynchronous, active-low reset (0 = reset)
//  req0_valid  in   1           req0 has a result to write
//  req0_ready  out  1           req0 result accepted this cycle
//  req0_addr   in   REG_ADDR_W  req0 destination register
//  req0_data   in   DATA_W      req0 result
//  req1_valid  in   1           req1 has a result to write
//  req1_ready  out  1           req1 result accepted this cycle
//  req1_addr   in   REG_ADDR_W  req1 destination register
//  req1_data   in   DATA_W      req1 result
//  rsv_valid   in   1           decode reserves a destination register
//  rsv_addr    in   REG_ADDR_W  register being reserved
//  flush       in   1           pipeline flush: drop all reservations
//  chk1_addr   in   REG_ADDR_W  decode source register 1
//  chk1_busy   out  1           source 1 has a pending write (stall)
//  chk2_addr   in   REG_ADDR_W  decode source register 2
//  chk2_busy   out  1           source 2 has a pending write (stall)
//  we          out  1           regfile write enable
//  waddr       out  REG_ADDR_W  regfile write address
//  wdata       out  DATA_W      regfile write data
// BEHAVIOUR
//  Reset (rst=0, async, immediate): we=0, waddr=0, wdata=0, req0/1_ready=0,
//   chk1/2_busy=0, scoreboard all 0, rr pointer=0 (req0 preferred).
//  Handshake: transfer when valid&&ready; ready is combinational from arbitration;
//   requester holds valid/addr/data stable until ready (bench assertion).
//  Arbitration: one grant per cycle. Only one valid -> it is granted. Both valid ->
//   grant the rr pointer; after any grant pointer = the other requester.
//  Output: granted transfer in cycle N -> we=1, waddr, wdata in cycle N+1, held
//   exactly one cycle; no grant in N -> we=0 in N+1 (waddr/wdata hold last value).
//  Addr 0: transfer is accepted (ready=1, pointer advances) but we stays 0 in N+1.
//  Scoreboard: REG_NUM-bit pending vector, bit 0 hard-wired 0.
//   rsv_valid && rsv_addr!=0 -> set bit next cycle.
//   we=1 -> clear bit waddr next cycle.
//   Set and clear of same bit in same cycle -> set wins (bit stays 1).
//   Reserving an already-pending bit leaves it 1; no counting (decode must not
//    issue a second writer to a busy reg; bench assertion).
//   flush=1 -> all bits 0 next cycle; rsv_valid same cycle ignored. Writes already
//    in flight still complete and drive we normally.
//  chkN_busy (combinational) = pending[chkN_addr] && !(we && waddr==chkN_addr);
//   addr 0 -> 0. While we=1 the regfile forwards wdata, so no stall that cycle.
// TESTING
//  1. Async reset mid-write (rst low between clocks while we=1) -> we, ready, busy
//     drop to 0 without a clock edge; after release pointer=0, scoreboard clear.
//  2. req0_valid, addr=5, data=0xDEADBEEF, req1 idle -> req0_ready=1 same cycle;
//     next cycle we=1, waddr=5, wdata=0xDEADBEEF; we=0 the cycle after.
//  3. Both valid continuously, 4 results each -> grants 0,1,0,1,0,1,0,1;
//     we=1 for 8 consecutive cycles starting one cycle after first grant.
//  4. rsv addr=7 -> chk1_busy=1 (chk1_addr=7) next cycle; req1 writes 7 ->
//     chk1_busy=0 in the cycle we=1 and stays 0 afterwards.
//  5. rsv addr=3 same cycle as we=1 waddr=3 -> bit 3 stays 1; rsv addr=0 and
//     req write to addr 0 -> no bit set, ready=1, we stays 0.
//  6. Reserve 1,2,9 then flush=1 with rsv addr=4 -> all busy 0 next cycle
//     (4 not set); in-flight write to 9 still produces we=1, waddr=9.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two result producers, decode, and the regfile write port.
// master = requesters/decode/regfile side, slave = regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [REG_ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0]     req0_data;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [REG_ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0]     req1_data;
    logic                  rsv_valid;
    logic [REG_ADDR_W-1:0] rsv_addr;
    logic                  flush;
    logic [REG_ADDR_W-1:0] chk1_addr;
    logic                  chk1_busy;
    logic [REG_ADDR_W-1:0] chk2_addr;
    logic                  chk2_busy;
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rsv_valid, rsv_addr, flush, chk1_addr, chk2_addr,
        input  req0_ready, req1_ready, chk1_busy, chk2_busy, we, waddr, wdata
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rsv_valid, rsv_addr, flush, chk1_addr, chk2_addr,
        output req0_ready, req1_ready, chk1_busy, chk2_busy, we, waddr, wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the regfile write port with a registered write stage
// and a pending-write scoreboard used by decode for RAW stalls.
module regfile_wb_arbiter #(
    parameter int REG_NUM    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic                  rr_p0;
    logic                  gnt0;
    logic                  gnt1;
    logic                  wr_nxt;
    logic                  we_p1;
    logic [REG_ADDR_W-1:0] waddr_p1;
    logic [DATA_W-1:0]     wdata_p1;
    logic [REG_NUM-1:0]    pending;
    logic [REG_NUM-1:0]    pend_nxt;

    always_comb begin
        gnt0   = bus.req0_valid && (!bus.req1_valid || !rr_p0);
        gnt1   = bus.req1_valid && (!bus.req0_valid ||  rr_p0);
        // addr 0 transfers are accepted but never reach the regfile
        wr_nxt = (gnt0 && (bus.req0_addr != '0)) || (gnt1 && (bus.req1_addr != '0));
    end

    always_comb begin
        pend_nxt = pending;
        if (we_p1)
            pend_nxt[waddr_p1] = 1'b0;
        if (bus.flush)
            pend_nxt = '0;
        else if (bus.rsv_valid && (bus.rsv_addr != '0))
            pend_nxt[bus.rsv_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // ---- grant stage -> registered write stage ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_p0    <= 1'b0;
            we_p1    <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            pending  <= '0;
        end else begin
            if (gnt0 || gnt1)
                rr_p0 <= gnt0;
            we_p1   <= wr_nxt;
            pending <= pend_nxt;
            if (wr_nxt) begin
                waddr_p1 <= gnt0 ? bus.req0_addr : bus.req1_addr;
                wdata_p1 <= gnt0 ? bus.req0_data : bus.req1_data;
            end
        end
    end

    // Ready is gated by reset so it drops immediately, without waiting for a clock.
    // A register being written this cycle is forwarded, so it never stalls.
    always_comb begin
        bus.req0_ready = rst && gnt0;
        bus.req1_ready = rst && gnt1;
        bus.we         = we_p1;
        bus.waddr      = waddr_p1;
        bus.wdata      = wdata_p1;
        bus.chk1_busy  = rst && pending[bus.chk1_addr] && !(we_p1 && (waddr_p1 == bus.chk1_addr));
        bus.chk2_busy  = rst && pending[bus.chk2_addr] && !(we_p1 && (waddr_p1 == bus.chk2_addr));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference arbiter predicts grants and
// queues expected regfile writes, a negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_err;
    logic rr_m;
    logic mon_en;
    wr_t  q[$];
    int   gq[$];

    regfile_wb_arbiter_if #(.REG_ADDR_W(5), .DATA_W(32)) r ();

    regfile_wb_arbiter #(.REG_NUM(32), .REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst) begin
            logic exp_we;
            wr_t  e;
            exp_we = (q.size() > 0) && (q[0].due == cyc);
            check("we", r.we, exp_we);
            if (exp_we) begin
                e = q.pop_front();
                check("waddr", r.waddr, e.addr);
                check("wdata", r.wdata, e.data);
            end
        end
    end

    task automatic eval();
        logic g0, g1;
        wr_t  e;
        g0 = r.req0_valid && (!r.req1_valid || !rr_m);
        g1 = r.req1_valid && (!r.req0_valid ||  rr_m);
        check("req0_ready", r.req0_ready, g0);
        check("req1_ready", r.req1_ready, g1);
        e.due = cyc + 1;
        if (g0) begin
            gq.push_back(0);
            e.addr = r.req0_addr;
            e.data = r.req0_data;
            if (e.addr != 5'd0) q.push_back(e);
            rr_m = 1'b1;
        end else if (g1) begin
            gq.push_back(1);
            e.addr = r.req1_addr;
            e.data = r.req1_data;
            if (e.addr != 5'd0) q.push_back(e);
            rr_m = 1'b0;
        end
    endtask

    task automatic cyc_go();
        #1;
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        r.req0_valid = 1'b0;
        r.req1_valid = 1'b0;
        r.rsv_valid  = 1'b0;
        r.flush      = 1'b0;
    endtask

    task automatic run(input int n0, input int n1, input logic [4:0] a0, input logic [4:0] a1);
        int i0;
        int i1;
        int k;
        i0 = 0;
        i1 = 0;
        gq.delete();
        for (int c = 0; c < 64 && (i0 < n0 || i1 < n1); c++) begin
            r.req0_valid = (i0 < n0);
            r.req0_addr  = a0 + 5'(i0);
            r.req0_data  = 32'hA000_0000 + 32'(a0) * 256 + 32'(i0);
            r.req1_valid = (i1 < n1);
            r.req1_addr  = a1 + 5'(i1);
            r.req1_data  = 32'hB000_0000 + 32'(a1) * 256 + 32'(i1);
            k = gq.size();
            #1;
            eval();
            if (gq.size() > k) begin
                if (gq[k] == 0) i0++;
                else            i1++;
            end
            @(posedge clk);
            #1;
        end
        drop();
        check("run_done", (i0 == n0) && (i1 == n1), 1'b1);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        cyc    = 0;
        rr_m   = 1'b0;
        mon_en = 1'b0;
        rst    = 1'b0;
        r.req0_addr = '0; r.req0_data = '0;
        r.req1_addr = '0; r.req1_data = '0;
        r.rsv_addr  = '0; r.chk1_addr = '0; r.chk2_addr = '0;
        drop();

        // reset state, with a request pending that must not be accepted
        repeat (3) @(posedge clk);
        #1;
        r.req0_valid = 1'b1;
        r.req0_addr  = 5'd5;
        r.chk1_addr  = 5'd5;
        #1;
        check("rst_ready0", r.req0_ready, 1'b0);
        check("rst_we",     r.we,         1'b0);
        check("rst_waddr",  r.waddr,      5'd0);
        check("rst_wdata",  r.wdata,      32'd0);
        check("rst_busy1",  r.chk1_busy,  1'b0);
        drop();
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // single write from req0
        r.req0_valid = 1'b1;
        r.req0_addr  = 5'd5;
        r.req0_data  = 32'hDEAD_BEEF;
        cyc_go();
        drop();
        cyc_go();
        cyc_go();
        // a lone req1 write returns the pointer to req0
        r.req1_valid = 1'b1;
        r.req1_addr  = 5'd6;
        r.req1_data  = 32'h0000_0606;
        cyc_go();
        drop();
        cyc_go();

        // both requesters streaming: strict alternation starting at req0
        run(4, 4, 5'd10, 5'd20);
        check("alt_cnt", gq.size(), 8);
        for (int k = 0; k < 8; k++)
            check("alt_order", (k < gq.size()) ? gq[k] : -1, k % 2);
        cyc_go();
        cyc_go();

        // reserve 7, then req1 writes 7
        r.rsv_valid = 1'b1;
        r.rsv_addr  = 5'd7;
        r.chk1_addr = 5'd7;
        cyc_go();
        drop();
        #1;
        check("rsv7_busy", r.chk1_busy, 1'b1);
        r.req1_valid = 1'b1;
        r.req1_addr  = 5'd7;
        r.req1_data  = 32'h0000_0777;
        cyc_go();
        drop();
        #1;
        check("wr7_fwd_busy", r.chk1_busy, 1'b0);
        cyc_go();
        #1;
        check("wr7_clr_busy", r.chk1_busy, 1'b0);

        // reserve on the same cycle as the write-back clear: set wins
        r.req0_valid = 1'b1;
        r.req0_addr  = 5'd3;
        r.req0_data  = 32'h0000_0333;
        r.rsv_valid  = 1'b1;
        r.rsv_addr   = 5'd3;
        r.chk2_addr  = 5'd3;
        cyc_go();
        drop();
        r.rsv_valid = 1'b1;
        r.rsv_addr  = 5'd3;
        #1;
        check("b3_fwd_busy", r.chk2_busy, 1'b0);
        cyc_go();
        drop();
        #1;
        check("b3_set_wins", r.chk2_busy, 1'b1);

        // address 0: accepted, no write, no reservation, pointer still advances
        r.rsv_valid  = 1'b1;
        r.rsv_addr   = 5'd0;
        r.req1_valid = 1'b1;
        r.req1_addr  = 5'd0;
        r.req1_data  = 32'h0000_1234;
        r.chk1_addr  = 5'd0;
        cyc_go();
        drop();
        #1;
        check("a0_busy", r.chk1_busy, 1'b0);
        run(1, 1, 5'd11, 5'd12);
        check("a0_ptr", (gq.size() > 0) ? gq[0] : -1, 0);
        cyc_go();
        cyc_go();

        // reserve 1,2,9; flush together with rsv 4 and an in-flight write to 9
        r.chk1_addr = 5'd1;
        r.chk2_addr = 5'd2;
        r.rsv_valid = 1'b1;
        r.rsv_addr  = 5'd1;
        cyc_go();
        r.rsv_addr  = 5'd2;
        cyc_go();
        r.rsv_addr  = 5'd9;
        cyc_go();
        drop();
        #1;
        check("pre_fl_busy1", r.chk1_busy, 1'b1);
        check("pre_fl_busy2", r.chk2_busy, 1'b1);
        r.chk1_addr = 5'd9;
        #1;
        check("pre_fl_busy9", r.chk1_busy, 1'b1);
        r.flush      = 1'b1;
        r.rsv_valid  = 1'b1;
        r.rsv_addr   = 5'd4;
        r.req1_valid = 1'b1;
        r.req1_addr  = 5'd9;
        r.req1_data  = 32'h0000_0999;
        cyc_go();
        drop();
        r.chk1_addr = 5'd1;
        r.chk2_addr = 5'd2;
        #1;
        check("fl_busy1", r.chk1_busy, 1'b0);
        check("fl_busy2", r.chk2_busy, 1'b0);
        r.chk1_addr = 5'd4;
        r.chk2_addr = 5'd9;
        cyc_go();
        #1;
        check("fl_busy4", r.chk1_busy, 1'b0);
        check("fl_busy9", r.chk2_busy, 1'b0);

        // asynchronous reset while a write is on the port
        r.rsv_valid = 1'b1;
        r.rsv_addr  = 5'd5;
        r.chk1_addr = 5'd5;
        cyc_go();
        drop();
        r.req0_valid = 1'b1;
        r.req0_addr  = 5'd8;
        r.req0_data  = 32'h0000_0888;
        cyc_go();
        #1;
        check("ar_pre_we",   r.we,        1'b1);
        check("ar_pre_busy", r.chk1_busy, 1'b1);
        mon_en = 1'b0;
        q.delete();
        rst  = 1'b0;
        rr_m = 1'b0;
        #1;
        check("ar_we",     r.we,         1'b0);
        check("ar_ready0", r.req0_ready, 1'b0);
        check("ar_busy1",  r.chk1_busy,  1'b0);
        check("ar_waddr",  r.waddr,      5'd0);
        drop();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        #1;
        check("ar_sb_clear", r.chk1_busy, 1'b0);
        run(1, 1, 5'd13, 5'd14);
        check("ar_ptr", (gq.size() > 0) ? gq[0] : -1, 0);

        cyc_go();
        cyc_go();
        check("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
